// File: rtl/block_aligner_param.sv
// block_aligner_param: 64b/66b sync-header hunt/lock block aligner for the gearbox output.
// Optional BLOCK_ALIGNER_STATS_EN adds saturating slip and locked-header-error counters.
module block_aligner_param #(
    parameter int BLOCK_W  = 66,
    parameter int BUF_W    = 194,
    parameter int LOCK_CNT = 64,
    parameter int WIN      = 64,
    parameter int BAD_MAX  = 16,
    localparam int OFF_W   = $clog2(BLOCK_W)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             buffer_dv,
    input  logic [BUF_W-1:0] gbox_buffer,
    input  logic             hunt_restart_i,
    output logic [OFF_W-1:0] block_offset,
    output logic             locked_o,
    output logic             hdr_valid_o,
    output logic             slip_o
`ifdef BLOCK_ALIGNER_STATS_EN
    ,
    output logic [15:0]      slip_cnt_o,
    output logic [15:0]      hdr_err_cnt_o
`endif
);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN + 1);
    localparam int IDX_W  = $clog2(BUF_W);

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t             r_state, w_state;
    logic [OFF_W-1:0]   r_off, w_off;
    logic [GOOD_W-1:0]  r_good, w_good;
    logic [WIN_W-1:0]   r_win, w_win, r_bad, w_bad;
    logic               r_hdr, w_hdr, r_slip, w_slip;

    // Header bit pair sits at MSB-k and MSB-k-1 of the buffer.
    logic [IDX_W-1:0]   w_idx;
    logic               w_valid;
    logic [OFF_W-1:0]   w_off_inc;
    logic [GOOD_W-1:0]  w_good_inc;
    logic [WIN_W-1:0]   w_win_inc, w_bad_inc;

    assign w_idx      = IDX_W'(BUF_W - 1) - IDX_W'(r_off);
    assign w_valid    = gbox_buffer[w_idx] ^ gbox_buffer[w_idx - 1'b1];
    assign w_off_inc  = (r_off == OFF_W'(BLOCK_W - 1)) ? '0 : r_off + 1'b1;
    assign w_good_inc = r_good + 1'b1;
    assign w_win_inc  = r_win + 1'b1;
    assign w_bad_inc  = r_bad + WIN_W'(!w_valid);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_HUNT;
            r_off   <= '0;
            r_good  <= '0;
            r_win   <= '0;
            r_bad   <= '0;
            r_hdr   <= 1'b0;
            r_slip  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_off   <= w_off;
            r_good  <= w_good;
            r_win   <= w_win;
            r_bad   <= w_bad;
            r_hdr   <= w_hdr;
            r_slip  <= w_slip;
        end
    end

    always_comb begin
        w_state = r_state;
        w_off   = r_off;
        w_good  = r_good;
        w_win   = r_win;
        w_bad   = r_bad;
        w_hdr   = 1'b0;
        w_slip  = 1'b0;
        if (hunt_restart_i) begin
            w_state = S_HUNT;
            w_good  = '0;
            w_win   = '0;
            w_bad   = '0;
        end else if (buffer_dv) begin
            if (r_state == S_HUNT) begin
                w_good = w_valid ? w_good_inc : '0;
                w_slip = !w_valid;
                w_off  = w_valid ? r_off : w_off_inc;
                if (w_valid && w_good_inc == GOOD_W'(LOCK_CNT)) begin
                    w_state = S_LOCKED;
                    w_good  = '0;
                    w_win   = '0;
                    w_bad   = '0;
                end
            end else begin
                w_hdr = w_valid;
                if (w_bad_inc == WIN_W'(BAD_MAX)) begin
                    w_state = S_HUNT;
                    w_good  = '0;
                    w_win   = '0;
                    w_bad   = '0;
                    w_off   = w_off_inc;
                    w_slip  = 1'b1;
                end else if (w_win_inc == WIN_W'(WIN)) begin
                    w_win = '0;
                    w_bad = '0;
                end else begin
                    w_win = w_win_inc;
                    w_bad = w_bad_inc;
                end
            end
        end
    end

    always_comb begin
        block_offset = r_off;
        locked_o     = (r_state == S_LOCKED);
        hdr_valid_o  = r_hdr;
        slip_o       = r_slip;
    end

`ifdef BLOCK_ALIGNER_STATS_EN
    logic [15:0] r_slip_cnt, r_err_cnt;
    logic        w_err;

    assign w_err = buffer_dv && !hunt_restart_i && r_state == S_LOCKED && !w_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slip_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_slip && r_slip_cnt != 16'hFFFF)
                r_slip_cnt <= r_slip_cnt + 1'b1;
            if (w_err && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign slip_cnt_o    = r_slip_cnt;
    assign hdr_err_cnt_o = r_err_cnt;
`endif
endmodule

// File: tb/tb_block_aligner_param.sv
// tb_block_aligner_param: directed self-checking bench for block_aligner_param (default and 34/100 sizing).
module tb_block_aligner_param;
    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         buffer_dv = 1'b0;
    logic         hunt_restart_i = 1'b0;
    logic [193:0] gbox_buffer = '0;
    logic [6:0]   block_offset;
    logic         locked_o, hdr_valid_o, slip_o;
    logic         s_dv = 1'b0;
    logic [99:0]  s_buf = '0;
    logic [5:0]   s_off;
    logic         s_locked, s_hdr, s_slip;
    logic [193:0] b183, zero;
    int           errors = 0;
    int           checks = 0;
`ifdef BLOCK_ALIGNER_STATS_EN
    logic [15:0]  slip_cnt_o, hdr_err_cnt_o, s_slip_cnt, s_err_cnt;
`endif

    always #5 clk = ~clk;

    block_aligner_param dut (
        .clk_i(clk), .rst_i(rst_i), .buffer_dv(buffer_dv), .gbox_buffer(gbox_buffer),
        .hunt_restart_i(hunt_restart_i), .block_offset(block_offset), .locked_o(locked_o),
        .hdr_valid_o(hdr_valid_o), .slip_o(slip_o)
`ifdef BLOCK_ALIGNER_STATS_EN
        , .slip_cnt_o(slip_cnt_o), .hdr_err_cnt_o(hdr_err_cnt_o)
`endif
    );

    block_aligner_param #(.BLOCK_W(34), .BUF_W(100)) dut_s (
        .clk_i(clk), .rst_i(rst_i), .buffer_dv(s_dv), .gbox_buffer(s_buf),
        .hunt_restart_i(1'b0), .block_offset(s_off), .locked_o(s_locked),
        .hdr_valid_o(s_hdr), .slip_o(s_slip)
`ifdef BLOCK_ALIGNER_STATS_EN
        , .slip_cnt_o(s_slip_cnt), .hdr_err_cnt_o(s_err_cnt)
`endif
    );

    task automatic step(input logic dv, input logic [193:0] b, input logic rs, input logic hr);
        @(negedge clk);
        buffer_dv = dv; s_dv = dv; gbox_buffer = b; rst_i = rs; hunt_restart_i = hr;
        @(posedge clk);
        #1;
        buffer_dv = 1'b0; s_dv = 1'b0; rst_i = 1'b0; hunt_restart_i = 1'b0;
    endtask

    task automatic do_lock();
        step(1'b0, zero, 1'b1, 1'b0);
        for (int i = 1; i <= 73; i++) step(1'b1, b183, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, zero, 1'b1, 1'b0);
        checks += 4;
        if (block_offset !== 7'd0) begin errors++; $display("FAIL reset_off got %0d exp 0", block_offset); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_lock got %b exp 0", locked_o); end
        if (hdr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_hdr got %b exp 0", hdr_valid_o); end
        if (slip_o !== 1'b0) begin errors++; $display("FAIL reset_slip got %b exp 0", slip_o); end
    endtask

    task automatic test_lock();
        for (int i = 1; i <= 73; i++) begin
            step(1'b1, b183, 1'b0, 1'b0);
            checks += 4;
            if (slip_o !== (i <= 9)) begin errors++; $display("FAIL lock_slip dv%0d got %b exp %b", i, slip_o, i <= 9); end
            if (block_offset !== 7'((i <= 9) ? i : 9)) begin errors++; $display("FAIL lock_off dv%0d got %0d", i, block_offset); end
            if (locked_o !== (i == 73)) begin errors++; $display("FAIL lock_state dv%0d got %b exp %b", i, locked_o, i == 73); end
            if (hdr_valid_o !== 1'b0) begin errors++; $display("FAIL lock_hdr dv%0d got %b exp 0", i, hdr_valid_o); end
            repeat (7) step(1'b0, zero, 1'b0, 1'b0);
        end
        checks += 2;
        if (slip_o !== 1'b0) begin errors++; $display("FAIL idle_slip got %b exp 0", slip_o); end
        if (locked_o !== 1'b1 || block_offset !== 7'd9) begin errors++; $display("FAIL locked_hold got %b/%0d exp 1/9", locked_o, block_offset); end
    endtask

    task automatic test_window();
        for (int j = 1; j <= 64; j++) begin
            step(1'b1, (j <= 15) ? zero : b183, 1'b0, 1'b0);
            checks += 2;
            if (locked_o !== 1'b1) begin errors++; $display("FAIL win1_lock dv%0d got %b exp 1", j, locked_o); end
            if (hdr_valid_o !== (j > 15)) begin errors++; $display("FAIL win1_hdr dv%0d got %b exp %b", j, hdr_valid_o, j > 15); end
        end
        for (int j = 1; j <= 16; j++) begin
            step(1'b1, zero, 1'b0, 1'b0);
            checks += 3;
            if (locked_o !== (j < 16)) begin errors++; $display("FAIL win2_lock dv%0d got %b exp %b", j, locked_o, j < 16); end
            if (slip_o !== (j == 16)) begin errors++; $display("FAIL win2_slip dv%0d got %b exp %b", j, slip_o, j == 16); end
            if (block_offset !== ((j == 16) ? 7'd10 : 7'd9)) begin errors++; $display("FAIL win2_off dv%0d got %0d", j, block_offset); end
        end
        for (int j = 1; j <= 64; j++) begin
            step(1'b1, b183, 1'b0, 1'b0);
            checks += 2;
            if (locked_o !== (j == 64)) begin errors++; $display("FAIL relock dv%0d got %b exp %b", j, locked_o, j == 64); end
            if (block_offset !== 7'd10 || slip_o !== 1'b0) begin errors++; $display("FAIL relock_off dv%0d got %0d/%b exp 10/0", j, block_offset, slip_o); end
        end
    endtask

    task automatic test_wrap();
        step(1'b0, zero, 1'b1, 1'b0);
        for (int i = 1; i <= 70; i++) begin
            step(1'b1, zero, 1'b0, 1'b0);
            checks += 3;
            if (slip_o !== 1'b1) begin errors++; $display("FAIL wrap_slip dv%0d got %b exp 1", i, slip_o); end
            if (block_offset !== 7'(i % 66)) begin errors++; $display("FAIL wrap_off dv%0d got %0d exp %0d", i, block_offset, i % 66); end
            if (locked_o !== 1'b0) begin errors++; $display("FAIL wrap_lock dv%0d got %b exp 0", i, locked_o); end
            if (i == 33 || i == 34 || i == 70) begin
                checks++;
                if (s_off !== 6'(i % 34)) begin errors++; $display("FAIL small_wrap dv%0d got %0d exp %0d", i, s_off, i % 34); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_lock();
        checks++;
        if (locked_o !== 1'b1) begin errors++; $display("FAIL pre_rst_lock got %b exp 1", locked_o); end
        step(1'b1, b183, 1'b1, 1'b0);
        checks += 3;
        if (block_offset !== 7'd0) begin errors++; $display("FAIL rst_mid_off got %0d exp 0", block_offset); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL rst_mid_lock got %b exp 0", locked_o); end
        if (slip_o !== 1'b0 || hdr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse got %b%b exp 00", slip_o, hdr_valid_o); end
        step(1'b1, b183, 1'b0, 1'b0);
        checks++;
        if (slip_o !== 1'b1 || block_offset !== 7'd1) begin errors++; $display("FAIL rst_resume got %b/%0d exp 1/1", slip_o, block_offset); end
        for (int i = 2; i <= 73; i++) step(1'b1, b183, 1'b0, 1'b0);
        checks++;
        if (locked_o !== 1'b1 || block_offset !== 7'd9) begin errors++; $display("FAIL rst_relock got %b/%0d exp 1/9", locked_o, block_offset); end
    endtask

    task automatic test_restart();
        do_lock();
        step(1'b1, zero, 1'b0, 1'b1);
        checks += 4;
        if (locked_o !== 1'b0) begin errors++; $display("FAIL rs_lock got %b exp 0", locked_o); end
        if (block_offset !== 7'd9) begin errors++; $display("FAIL rs_off got %0d exp 9", block_offset); end
        if (slip_o !== 1'b0) begin errors++; $display("FAIL rs_slip got %b exp 0", slip_o); end
        if (hdr_valid_o !== 1'b0) begin errors++; $display("FAIL rs_hdr got %b exp 0", hdr_valid_o); end
        for (int j = 1; j <= 64; j++) begin
            step(1'b1, b183, 1'b0, 1'b0);
            if (j >= 63) begin
                checks++;
                if (locked_o !== (j == 64) || block_offset !== 7'd9) begin errors++; $display("FAIL rs_relock dv%0d got %b/%0d", j, locked_o, block_offset); end
            end
        end
    endtask

`ifdef BLOCK_ALIGNER_STATS_EN
    task automatic test_stats();
        step(1'b0, zero, 1'b1, 1'b0);
        checks++;
        if (slip_cnt_o !== 16'd0 || hdr_err_cnt_o !== 16'd0) begin errors++; $display("FAIL st_reset got %0d/%0d exp 0/0", slip_cnt_o, hdr_err_cnt_o); end
        for (int i = 1; i <= 73; i++) step(1'b1, b183, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) step(1'b1, zero, 1'b0, 1'b0);
        checks += 2;
        if (slip_cnt_o !== 16'd10) begin errors++; $display("FAIL st_slip got %0d exp 10", slip_cnt_o); end
        if (hdr_err_cnt_o !== 16'd16) begin errors++; $display("FAIL st_err got %0d exp 16", hdr_err_cnt_o); end
        step(1'b0, zero, 1'b0, 1'b1);
        checks++;
        if (slip_cnt_o !== 16'd10 || hdr_err_cnt_o !== 16'd16) begin errors++; $display("FAIL st_restart got %0d/%0d exp 10/16", slip_cnt_o, hdr_err_cnt_o); end
    endtask
`endif

    initial begin
        b183 = '0;
        b183[183] = 1'b1;
        zero = '0;
        test_reset();
        test_lock();
        test_window();
        test_wrap();
        test_reset_mid();
        test_restart();
`ifdef BLOCK_ALIGNER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/block_aligner_param.md
Name: block_aligner_param

Overview:
Parametrised sync-header block aligner for the Aurora-style 64b/66b RX path. It sits after the gearbox and takes the gearbox buffer plus its data-valid strobe. It hunts for the bit offset at which the 2-bit sync header is valid, locks with a consecutive-good threshold and unlocks on a bad-header-per-window criterion. It reports the block offset, lock status and per-block header status to the descrambler/framer.

Parameters:
BLOCK_W, 66, block length in bits including the 2-bit header; candidate offsets are 0..BLOCK_W-1.
BUF_W, 194, gearbox buffer width; must be >= BLOCK_W+1.
LOCK_CNT, 64, consecutive valid headers required in HUNT to enter LOCKED.
WIN, 64, headers per error window in LOCKED.
BAD_MAX, 16, invalid headers within one window that force unlock; must be <= WIN.
Derived: OFF_W = $clog2(BLOCK_W). Counter widths are sized from LOCK_CNT and WIN.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
buffer_dv  in  1  gearbox buffer valid, one-cycle strobe per block
gbox_buffer  in  BUF_W  gearbox buffer, MSB oldest
hunt_restart_i  in  1  synchronous request: drop lock, restart hunt at current offset
block_offset  out  OFF_W  current candidate / locked offset
locked_o  out  1  block lock
hdr_valid_o  out  1  one-cycle pulse: header valid on this block while LOCKED
slip_o  out  1  one-cycle pulse: offset advanced

Behaviour:
- Header at offset k is the bit pair {gbox_buffer[BUF_W-1-k], gbox_buffer[BUF_W-2-k]}. It is valid iff the two bits differ (01 or 10).
- All outputs are registered. A dv in cycle n is evaluated combinationally; its results appear after the edge ending cycle n, i.e. latency 1.
- Reset: state HUNT, block_offset=0, locked_o=0, hdr_valid_o=0, slip_o=0, all counters 0. Reset mid-operation overrides everything.
- HUNT state, on each dv:
  - Valid header: good+1. If good+1 == LOCK_CNT, go to LOCKED, set locked_o=1, clear win/bad.
  - Invalid header: good=0, slip_o=1, block_offset = (block_offset==BLOCK_W-1) ? 0 : block_offset+1.
- LOCKED state, on each dv:
  - win_n = win+1; bad_n = bad + invalid. hdr_valid_o = valid.
  - If bad_n == BAD_MAX: go to HUNT, locked_o=0, good=0, advance offset with wrap, slip_o=1.
  - Else if win_n == WIN: win=0, bad=0. The completing dv counts toward the closed window.
  - Else store win_n and bad_n.
- No dv: state and counters hold. Pulses hdr_valid_o and slip_o are 0.
- hunt_restart_i: go to HUNT, locked_o=0, all counters 0, offset unchanged, no slip pulse. If it coincides with dv, restart wins and that dv is ignored.
- Precedence: rst_i > hunt_restart_i > buffer_dv.
- dv on consecutive cycles is legal; each dv is evaluated independently.

Optional Feature:
BLOCK_ALIGNER_STATS_EN
- Defined: adds outputs slip_cnt_o[15:0] and hdr_err_cnt_o[15:0].
  - slip_cnt_o counts slip_o pulses. hdr_err_cnt_o counts invalid headers seen while LOCKED.
  - Both saturate at 16'hFFFF and clear on rst_i only; hunt_restart_i does not clear them.
  - Both are registered, updated in the same cycle as the corresponding pulse/state update.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Defaults, gbox_buffer with only bit 183 set, dv every 8 cycles -> slip_o on dv 1..9 (offsets 1..9); offset 9 valid ("01"); locked_o=1 one cycle after dv 73; block_offset=9.
2. From scenario 1 lock: 15 all-zero buffers inside one 64-dv window, rest bit 183 -> stays locked, window resets at dv 64. Then 16 zero buffers in the next window -> on the 16th: locked_o=0, slip_o=1, block_offset=10. Restore bit 183 ("10" at offset 10) -> relock after 64 dvs at offset 10.
3. All-zero buffer, 70 dvs -> slip_o each dv; block_offset goes 1..65, then 0 after dv 66, then 4 after dv 70; locked_o stays 0.
4. Locked at offset 9, assert rst_i for 1 cycle -> next cycle block_offset=0, locked_o=0, no pulses; hunt resumes correctly.
5. Locked, hunt_restart_i and dv in the same cycle -> locked_o=0, block_offset=9, slip_o=0, hdr_valid_o=0. Relock after 64 further valid dvs.
6. With BLOCK_ALIGNER_STATS_EN, scenario 1 then 16 bad headers -> slip_cnt_o=10, hdr_err_cnt_o=16. BLOCK_W=34, BUF_W=100 all-zero -> block_offset wraps 33->0.
